// File: rtl/riscv_prefetch_buffer_mo.sv
// Multi-outstanding instruction prefetch buffer: pipelined word fetches with FIFO slot
// reservation and stale-response dropping after redirects. Optional RISCV_PF_HWLP_EN.
module riscv_prefetch_buffer_mo #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
`ifdef RISCV_PF_HWLP_EN
    input  logic        hwloop_jump_i,
    input  logic [31:0] hwloop_target_i,
    output logic        is_hwlp_o,
`endif

    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,

    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        busy_o
);

    localparam int unsigned OutW = $clog2(MAX_OUT + 1);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OutW-1:0] out_q, out_d;
    logic [OutW-1:0] drop_q, drop_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]     fetch_addr_q, fetch_addr_d;
    logic [31:0]     resp_addr_q, resp_addr_d;
    logic            pend_q, pend_d;
    logic            run_q;

    logic [31:0]     data_q [DEPTH];
    logic [31:0]     eaddr_q [DEPTH];

    logic            redirect;
    logic [31:0]     target;
    logic [31:0]     live;
    logic [31:0]     occ;
    logic            issue_ok;
    logic            gnt_fire;
    logic            push;
    logic            pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        redirect = branch_i;
        target   = addr_i;
`ifdef RISCV_PF_HWLP_EN
        if (!branch_i && hwloop_jump_i) begin
            redirect = 1'b1;
            target   = hwloop_target_i;
        end
`endif
    end

    // In-flight requests already own a FIFO slot; a redirect frees every slot this cycle.
    assign live     = 32'(out_q) - 32'(drop_q);
    assign occ      = redirect ? 32'd0 : 32'(cnt_q);
    assign issue_ok = req_i & (32'(out_q) < MAX_OUT) & ((live + occ) < DEPTH);

    // run_q keeps the request low while reset is (or was just) asserted.
    assign instr_req_o  = run_q & (issue_ok | pend_q);
    assign instr_addr_o = redirect ? {target[31:2], 2'b00} : fetch_addr_q;
    assign gnt_fire     = instr_req_o & instr_gnt_i;

    assign valid_o = (cnt_q != '0);
    assign push    = instr_rvalid_i & ~redirect & (drop_q == '0);
    assign pop     = ready_i & valid_o & ~redirect;
    assign rdata_o = data_q[rd_ptr_q];
    assign addr_o  = eaddr_q[rd_ptr_q];
    assign busy_o  = (out_q != '0) | instr_req_o;

    always_comb begin
        out_d        = out_q + OutW'(gnt_fire) - OutW'(instr_rvalid_i);
        drop_d       = drop_q;
        cnt_d        = cnt_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        fetch_addr_d = fetch_addr_q;
        resp_addr_d  = resp_addr_q;
        pend_d       = instr_req_o & ~instr_gnt_i;

        if (gnt_fire) begin
            fetch_addr_d = instr_addr_o + 32'd4;
        end else if (redirect) begin
            fetch_addr_d = {target[31:2], 2'b00};
        end

        if (redirect) begin
            // Everything still outstanding belongs to the old stream.
            drop_d      = out_q - OutW'(instr_rvalid_i);
            cnt_d       = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            resp_addr_d = target;
        end else begin
            if (instr_rvalid_i && (drop_q != '0)) begin
                drop_d = drop_q - OutW'(1);
            end
            if (push) begin
                wr_ptr_d    = ptr_inc(wr_ptr_q);
                resp_addr_d = {resp_addr_q[31:2], 2'b00} + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            drop_q       <= '0;
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fetch_addr_q <= '0;
            resp_addr_q  <= '0;
            pend_q       <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            out_q        <= out_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            fetch_addr_q <= fetch_addr_d;
            resp_addr_q  <= resp_addr_d;
            pend_q       <= pend_d;
            run_q        <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i]  <= '0;
                eaddr_q[i] <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q]  <= instr_rdata_i;
            eaddr_q[wr_ptr_q] <= resp_addr_q;
        end
    end

`ifdef RISCV_PF_HWLP_EN
    logic hwlp_pend_q, hwlp_pend_d;
    logic hwlp_q [DEPTH];

    // Tags only the first surviving word after a hardware-loop jump.
    always_comb begin
        hwlp_pend_d = hwlp_pend_q;
        if (branch_i) begin
            hwlp_pend_d = 1'b0;
        end else if (hwloop_jump_i) begin
            hwlp_pend_d = 1'b1;
        end else if (push) begin
            hwlp_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwlp_pend_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                hwlp_q[i] <= 1'b0;
            end
        end else begin
            hwlp_pend_q <= hwlp_pend_d;
            if (push) begin
                hwlp_q[wr_ptr_q] <= hwlp_pend_q;
            end
        end
    end

    assign is_hwlp_o = valid_o & hwlp_q[rd_ptr_q];
`endif

endmodule
